udp_tx_scheduler: RTL and testbench

- Shares the single UDP/MAC transmit engine between two byte-stream sources: ch0 (audio) and ch1 (video).
- Each source has its own dual-clock FIFO, read on the GMII side.
- The block watches FIFO water levels and picks a channel round-robin. It then starts the engine with a packet length and routes the engine's byte reads to the granted FIFO.
- It enforces an inter-packet gap and a watchdog, and sits between the pre-transmit FIFOs and the MAC/UDP packetiser.

---
 rtl/udp_tx_scheduler.sv | 138 +++++++++++++
 tb/tb_udp_tx_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_scheduler.sv
// Round-robin scheduler sharing one UDP/MAC transmit engine between two FIFO-fed
// byte streams, with flush-driven partial packets, inter-packet gap and watchdog.
module udp_tx_scheduler #(
  parameter int unsigned PKT_LEN    = 1024,
  parameter int unsigned LVL_W      = 11,
  parameter int unsigned GAP_CYCLES = 12,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic             gmii_tx_clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [LVL_W-1:0] ch0_level,
  input  logic [LVL_W-1:0] ch1_level,
  input  logic             ch0_flush,
  input  logic             ch1_flush,
  input  logic [7:0]       ch0_data,
  input  logic [7:0]       ch1_data,
  output logic             ch0_rd_en,
  output logic             ch1_rd_en,
  input  logic             udp_rd_en,
  output logic [7:0]       udp_data,
  input  logic             udp_done,
  output logic             udp_start,
  output logic [15:0]      udp_len,
  output logic             udp_chan,
  output logic             busy,
  output logic             err
);

  localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [LVL_W:0]   PKT_LEN_L = (LVL_W + 1)'(PKT_LEN);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, XFER, GAP} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic             flush0_pend, flush1_pend;
  logic             full0, full1, elig0, elig1;
  logic             start_req, grant_nxt;
  logic [15:0]      len_nxt;
  logic [15:0]      remain;
  logic [WD_W-1:0]  wd_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             wd_expired;
  logic             xfer_rd, fwd_rd;

  assign full0 = {1'b0, ch0_level} >= PKT_LEN_L;
  assign full1 = {1'b0, ch1_level} >= PKT_LEN_L;
  assign elig0 = full0 || (flush0_pend && (ch0_level != '0));
  assign elig1 = full1 || (flush1_pend && (ch1_level != '0));

  assign start_req = enable && (elig0 || elig1);
  // With both eligible, the channel not served last wins; otherwise the lone one.
  assign grant_nxt = (elig0 && elig1) ? ~last_grant : elig1;

  always_comb begin
    len_nxt = '0;
    if (grant_nxt) len_nxt = full1 ? 16'(PKT_LEN) : 16'(ch1_level);
    else           len_nxt = full0 ? 16'(PKT_LEN) : 16'(ch0_level);
  end

  assign wd_expired = (wd_cnt == WD_LAST);
  assign xfer_rd    = (state == XFER) && udp_rd_en;
  assign fwd_rd     = xfer_rd && (remain != '0);

  always_ff @(posedge gmii_tx_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_req) state_nxt = START;
      START:   state_nxt = XFER;
      XFER:    if (udp_done || wd_expired) state_nxt = GAP;
      GAP:     if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    udp_start = (state == START);
    busy      = (state != IDLE);
    ch0_rd_en = fwd_rd && !udp_chan;
    ch1_rd_en = fwd_rd && udp_chan;
    udp_data  = '0;
    if (state == XFER) udp_data = udp_chan ? ch1_data : ch0_data;
  end

  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      last_grant  <= 1'b1;
      udp_chan    <= 1'b0;
      udp_len     <= '0;
      flush0_pend <= 1'b0;
      flush1_pend <= 1'b0;
      remain      <= '0;
      wd_cnt      <= '0;
      gap_cnt     <= '0;
      err         <= 1'b0;
    end else begin
      // Later assignments win: a flush in the same cycle as a clear keeps the flag set.
      if (state == IDLE && start_req && !grant_nxt) flush0_pend <= 1'b0;
      if (state == IDLE && ch0_level == '0)         flush0_pend <= 1'b0;
      if (ch0_flush)                                flush0_pend <= 1'b1;
      if (state == IDLE && start_req && grant_nxt)  flush1_pend <= 1'b0;
      if (state == IDLE && ch1_level == '0)         flush1_pend <= 1'b0;
      if (ch1_flush)                                flush1_pend <= 1'b1;

      if (state == IDLE && start_req) begin
        udp_chan   <= grant_nxt;
        last_grant <= grant_nxt;
        udp_len    <= len_nxt;
      end

      if (state == START) begin
        remain <= udp_len;
        wd_cnt <= '0;
      end

      if (state == XFER) begin
        wd_cnt <= wd_cnt + 1'b1;
        if (fwd_rd) remain <= remain - 1'b1;
        if (xfer_rd && remain == '0)  err <= 1'b1;
        if (udp_done && remain != '0) err <= 1'b1;
        if (wd_expired)               err <= 1'b1;
      end

      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      else              gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Directed-sequence bench for udp_tx_scheduler with randomized engine timing and
// FIFO data, checked against a packet-level model of grant/length/error rules.
module tb_udp_tx_scheduler;

  localparam int unsigned PKT = 1024;
  localparam int unsigned LW  = 11;
  localparam int unsigned GAP = 12;
  localparam int unsigned TO  = 3000;

  logic          gmii_tx_clk = 1'b0;
  logic          rst, enable;
  logic [LW-1:0] ch0_level, ch1_level;
  logic          ch0_flush, ch1_flush;
  logic [7:0]    ch0_data, ch1_data;
  logic          ch0_rd_en, ch1_rd_en;
  logic          udp_rd_en;
  logic [7:0]    udp_data;
  logic          udp_done, udp_start;
  logic [15:0]   udp_len;
  logic          udp_chan, busy, err;

  always #5 gmii_tx_clk = ~gmii_tx_clk;

  udp_tx_scheduler #(
    .PKT_LEN(PKT), .LVL_W(LW), .GAP_CYCLES(GAP), .TIMEOUT(TO)
  ) dut (
    .gmii_tx_clk(gmii_tx_clk), .rst(rst), .enable(enable),
    .ch0_level(ch0_level), .ch1_level(ch1_level),
    .ch0_flush(ch0_flush), .ch1_flush(ch1_flush),
    .ch0_data(ch0_data), .ch1_data(ch1_data),
    .ch0_rd_en(ch0_rd_en), .ch1_rd_en(ch1_rd_en),
    .udp_rd_en(udp_rd_en), .udp_data(udp_data), .udp_done(udp_done),
    .udp_start(udp_start), .udp_len(udp_len), .udp_chan(udp_chan),
    .busy(busy), .err(err)
  );

  int checks   = 0;
  int failures = 0;

  // Packet-level reference state
  bit pend[2];
  bit last_g;
  bit err_m;
  int cur_chan;
  int cur_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge gmii_tx_clk);
    #1;
  endtask

  function automatic bit elig(input int c);
    int l;
    l = (c != 0) ? int'(ch1_level) : int'(ch0_level);
    return (l >= int'(PKT)) || (pend[c] && l != 0);
  endfunction

  // Called while udp_start is observed high; levels are unchanged since the grant edge.
  task automatic expect_start();
    bit e0, e1;
    int c, l;
    e0 = elig(0);
    e1 = elig(1);
    c  = (e0 && e1) ? int'(!last_g) : (e1 ? 1 : 0);
    l  = (c != 0) ? int'(ch1_level) : int'(ch0_level);
    if (l > int'(PKT)) l = int'(PKT);
    chk("udp_chan", 32'(udp_chan), 32'(c));
    chk("udp_len", 32'(udp_len), 32'(l));
    chk("udp_data_idle", 32'(udp_data), 32'd0);
    last_g   = c[0];
    pend[c]  = 1'b0;
    cur_chan = c;
    cur_len  = l;
  endtask

  // Emulates the engine: n_reads requests at random spacing, then a done pulse.
  task automatic xfer(input int n_reads);
    int rem, issued, guard;
    bit e0, e1;
    rem = cur_len;
    issued = 0;
    guard = 0;
    while (issued < n_reads && guard < 4 * n_reads + 10) begin
      tick();
      guard++;
      ch0_data  = 8'($urandom);
      ch1_data  = 8'($urandom);
      udp_rd_en = ($urandom_range(3) != 0);
      #1;
      e0 = udp_rd_en && cur_chan == 0 && rem != 0;
      e1 = udp_rd_en && cur_chan == 1 && rem != 0;
      chk("ch0_rd_en", 32'(ch0_rd_en), 32'(e0));
      chk("ch1_rd_en", 32'(ch1_rd_en), 32'(e1));
      chk("udp_data", 32'(udp_data), 32'((cur_chan != 0) ? ch1_data : ch0_data));
      if (udp_rd_en) begin
        if (rem == 0) err_m = 1'b1;
        else rem--;
        issued++;
      end
    end
    chk("reads_issued", 32'(issued), 32'(n_reads));
    tick();
    udp_rd_en = 1'b0;
    udp_done  = 1'b1;
    if (rem != 0) err_m = 1'b1;
    tick();
    udp_done = 1'b0;
    chk("err_after_done", 32'(err), 32'(err_m));
    chk("busy_in_gap", 32'(busy), 32'd1);
  endtask

  task automatic wait_start(input int max, output int cyc, output bit got, output bit any_rd);
    got = 1'b0;
    any_rd = 1'b0;
    cyc = 0;
    while (!got && cyc < max) begin
      tick();
      cyc++;
      if (ch0_rd_en || ch1_rd_en) any_rd = 1'b1;
      if (udp_start) got = 1'b1;
    end
  endtask

  initial begin
    int cyc;
    bit got, any_rd;

    rst = 1'b1; enable = 1'b0;
    ch0_level = '0; ch1_level = '0; ch0_flush = 1'b0; ch1_flush = 1'b0;
    ch0_data = '0; ch1_data = '0; udp_rd_en = 1'b0; udp_done = 1'b0;
    pend = '{1'b0, 1'b0}; last_g = 1'b1; err_m = 1'b0;
    cur_chan = 0; cur_len = 0;
    repeat (3) tick();

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_start", 32'(udp_start), 32'd0);
    chk("rst_rd0", 32'(ch0_rd_en), 32'd0);
    chk("rst_rd1", 32'(ch1_rd_en), 32'd0);
    chk("rst_len", 32'(udp_len), 32'd0);
    chk("rst_chan", 32'(udp_chan), 32'd0);
    chk("rst_data", 32'(udp_data), 32'd0);
    rst = 1'b0;
    tick();

    // Full ch0 packet: start one clock after eligibility is sampled
    ch0_level = 11'd1024; enable = 1'b1;
    #1 chk("idle_no_start", 32'(udp_start), 32'd0);
    tick();
    chk("start_latency", 32'(udp_start), 32'd1);
    expect_start();
    xfer(cur_len);
    // From the done-sampling edge: GAP_CYCLES in GAP plus one IDLE clock
    wait_start(40, cyc, got, any_rd);
    chk("start_after_gap", 32'(got), 32'd1);
    chk("done_to_start", 32'(cyc), 32'(GAP + 1));
    expect_start();

    ch0_level = 11'd2000; ch1_level = 11'd2000;
    xfer(cur_len);
    for (int i = 0; i < 3; i++) begin
      wait_start(40, cyc, got, any_rd);
      chk("rr_start", 32'(got), 32'd1);
      expect_start();
      xfer(cur_len);
    end

    // Partial ch1 packet via flush
    ch0_level = '0; ch1_level = 11'd300;
    ch1_flush = 1'b1; pend[1] = 1'b1;
    tick();
    ch1_flush = 1'b0;
    wait_start(40, cyc, got, any_rd);
    chk("flush_start", 32'(got), 32'd1);
    expect_start();
    xfer(cur_len);

    // Flush with an empty FIFO: no packet, and the flag must not linger
    ch1_level = '0;
    ch1_flush = 1'b1; pend[1] = 1'b1;
    tick();
    ch1_flush = 1'b0;
    wait_start(40, cyc, got, any_rd);
    chk("flush_empty_nostart", 32'(got), 32'd0);
    pend[1] = 1'b0;
    ch1_level = 11'd5;
    wait_start(40, cyc, got, any_rd);
    chk("flag_cleared", 32'(got), 32'(elig(0) || elig(1)));

    // Flush with level above PKT_LEN: full packet, residue waits
    enable = 1'b0; ch1_level = '0; ch0_level = 11'd1500;
    ch0_flush = 1'b1; pend[0] = 1'b1;
    tick();
    ch0_flush = 1'b0; enable = 1'b1;
    wait_start(40, cyc, got, any_rd);
    chk("flush_full_start", 32'(got), 32'd1);
    expect_start();
    ch0_level = 11'd476;
    xfer(cur_len);
    wait_start(40, cyc, got, any_rd);
    chk("residue_waits", 32'(got), 32'd0);

    // Engine over-read: 1025 requests for a 1024-byte packet
    ch0_level = 11'd1024;
    wait_start(40, cyc, got, any_rd);
    chk("overrun_start", 32'(got), 32'd1);
    expect_start();
    xfer(cur_len + 1);
    repeat (5) tick();
    chk("err_sticky", 32'(err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; err_m = 1'b0; last_g = 1'b1; pend = '{1'b0, 1'b0};
    chk("err_cleared_by_rst", 32'(err), 32'd0);

    // Early done after 1000 reads
    wait_start(40, cyc, got, any_rd);
    chk("short_start", 32'(got), 32'd1);
    expect_start();
    xfer(1000);

    // Reset mid-transfer with the engine still requesting
    wait_start(40, cyc, got, any_rd);
    chk("midrst_start", 32'(got), 32'd1);
    expect_start();
    tick();
    udp_rd_en = 1'b1;
    repeat (10) tick();
    rst = 1'b1; enable = 1'b0;
    tick();
    rst = 1'b0; err_m = 1'b0; last_g = 1'b1; pend = '{1'b0, 1'b0};
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_rd0", 32'(ch0_rd_en), 32'd0);
    chk("midrst_rd1", 32'(ch1_rd_en), 32'd0);
    chk("midrst_len", 32'(udp_len), 32'd0);
    chk("midrst_data", 32'(udp_data), 32'd0);
    wait_start(60, cyc, got, any_rd);
    chk("disabled_nostart", 32'(got), 32'd0);
    chk("disabled_no_rd", 32'(any_rd), 32'd0);

    // Watchdog: engine never reads nor finishes
    udp_rd_en = 1'b0; enable = 1'b1;
    wait_start(40, cyc, got, any_rd);
    chk("wd_start", 32'(got), 32'd1);
    expect_start();
    cyc = 0;
    while (!err && cyc < int'(TO) + 20) begin
      tick();
      cyc++;
    end
    // One clock START->XFER, then TIMEOUT clocks in XFER
    chk("wd_abort_cycles", 32'(cyc), 32'(TO + 1));
    chk("wd_err", 32'(err), 32'd1);
    wait_start(40, cyc, got, any_rd);
    chk("wd_next_start", 32'(got), 32'd1);
    chk("wd_gap", 32'(cyc), 32'(GAP + 1));
    expect_start();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
